// File: rtl/acc_buf_ctrl.sv
// Sequencer for the 8-lane accumulation buffer: walks one output tile across all
// input channels, issuing read strobes and delayed write strobes with per-write flags.
module acc_buf_ctrl #(
    parameter int unsigned DEPTH    = 114*114,
    parameter int unsigned ADDR_BIT = 14,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned CH_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_BIT-1:0] cfg_pix_num,
    input  logic [CH_W-1:0]     cfg_ch_num,
    input  logic                in_valid,
    input  logic                in_zero,
    output logic                in_ready,
    output logic                read_en,
    output logic [ADDR_BIT-1:0] read_addr,
    output logic                write_en,
    output logic [ADDR_BIT-1:0] write_addr,
    output logic                prev_data_zero,
    output logic                curr_data_zero,
    output logic                out_valid,
    output logic                busy,
    output logic                done
);
    localparam int unsigned DRAIN_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t              state, next_state;
    logic [ADDR_BIT-1:0] pix_num, pix_cnt;
    logic [CH_W-1:0]     ch_num, ch_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                accept, pix_last, ch_last, drain_end;
    logic                in_ready_d, busy_d, done_d;

    logic [RD_LAT-1:0]   pipe_v, pipe_first, pipe_last, pipe_zero;
    logic [ADDR_BIT-1:0] pipe_addr [RD_LAT];

    assign accept    = (state == ACC) && in_valid;
    assign pix_last  = (pix_cnt == pix_num - ADDR_BIT'(1));
    assign ch_last   = (ch_cnt == ch_num - CH_W'(1));
    assign drain_end = (drain_cnt == DRAIN_W'(RD_LAT));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (cfg_pix_num == '0) ? DONE : ACC;
            ACC:     if (accept && pix_last) next_state = DRAIN;
            DRAIN:   if (drain_end) next_state = ch_last ? DONE : ACC;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode; registered below so the ports come straight from flops
    always_comb begin
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        if (next_state == ACC)  in_ready_d = 1'b1;
        if (next_state != IDLE) busy_d     = 1'b1;
        if (state == DONE)      done_d     = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            in_ready <= in_ready_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Tile configuration and pixel/channel/drain counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_num   <= '0;
            ch_num    <= '0;
            pix_cnt   <= '0;
            ch_cnt    <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                pix_num <= (cfg_pix_num > ADDR_BIT'(DEPTH)) ? ADDR_BIT'(DEPTH) : cfg_pix_num;
                ch_num  <= (cfg_ch_num == '0) ? CH_W'(1) : cfg_ch_num;
                pix_cnt <= '0;
                ch_cnt  <= '0;
            end
            if (accept) pix_cnt <= pix_last ? '0 : pix_cnt + ADDR_BIT'(1);
            if (state == DRAIN) begin
                drain_cnt <= drain_end ? '0 : drain_cnt + DRAIN_W'(1);
                if (drain_end && !ch_last) ch_cnt <= ch_cnt + CH_W'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // Read strobe plus RD_LAT-deep delay line feeding the write strobe and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v         <= '0;
            pipe_first     <= '0;
            pipe_last      <= '0;
            pipe_zero      <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) pipe_addr[i] <= '0;
            read_en        <= 1'b0;
            read_addr      <= '0;
            write_en       <= 1'b0;
            write_addr     <= '0;
            prev_data_zero <= 1'b0;
            curr_data_zero <= 1'b0;
            out_valid      <= 1'b0;
        end else begin
            pipe_v[0]     <= accept;
            pipe_addr[0]  <= accept ? pix_cnt : '0;
            pipe_first[0] <= accept && (ch_cnt == '0);
            pipe_last[0]  <= accept && ch_last;
            pipe_zero[0]  <= accept && in_zero;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_v[i]     <= pipe_v[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
                pipe_first[i] <= pipe_first[i-1];
                pipe_last[i]  <= pipe_last[i-1];
                pipe_zero[i]  <= pipe_zero[i-1];
            end
            read_en <= accept;
            if (accept) read_addr <= pix_cnt;
            write_en       <= pipe_v[RD_LAT-1];
            write_addr     <= pipe_addr[RD_LAT-1];
            prev_data_zero <= pipe_first[RD_LAT-1];
            curr_data_zero <= pipe_zero[RD_LAT-1];
            out_valid      <= pipe_last[RD_LAT-1];
        end
    end
endmodule
